// File: rtl/b1r2_code_decoder.sv
// -----------------------------------------------------------------------------
// b1r2_code_decoder
//
// Receive side of the 3-to-4 b1_r2 line code. Each 4-bit code word
// (bit0=c0 .. bit3=c3) arriving on a valid/ready stream is checked against the
// code rules and split back into its symbol fields:
//   sym2     = c0
//   pair_eq  = ~c1                   (symbol bits 0 and 1 were equal)
//   pair_val = pair_eq ? c2^c0 : 0   (their common value)
// A word is valid iff c3 == ~c0 and not (c1 & c2).
//
// Decoded entries are buffered in a small output FIFO (FIFO_DEPTH = 2 or 4),
// with full/empty taken from an explicit occupancy counter. Invalid words are
// counted in a saturating counter and latched in a sticky flag. When the
// counter saturates, the block stops accepting (FLUSH state) until the FIFO
// has drained and clr_err has been seen.
//
// Optional build macro B1R2_DEC_DROP_INVALID_EN:
//   defined   - invalid words are accepted and counted but never buffered;
//               out_err is always 0.
//   undefined - invalid words are buffered with out_err = 1.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready code-word handshake; in_ready is a register and does
//                     not depend on out_ready
//   in_code[3:0]      code word c3..c0
//   out_valid/out_ready decoded-entry handshake
//   out_sym2, out_pair_eq, out_pair_val, out_err   head-of-FIFO fields
//   err_cnt[CNT_W-1:0] saturating count of accepted invalid words
//   err_sticky        set by the first invalid word
//   clr_err           synchronous clear of err_cnt/err_sticky, also releases
//                     FLUSH once the FIFO is empty
// -----------------------------------------------------------------------------
module b1r2_code_decoder #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sym2,
  output logic             out_pair_eq,
  output logic             out_pair_val,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky,
  input  logic             clr_err
);

  // FIFO_DEPTH is limited to 2 or 4, so one or two pointer bits suffice and a
  // 3-bit occupancy counter covers 0..4.
  localparam int PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int OCC_W = 3;

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE   = 3'd1;
  localparam logic [OCC_W-1:0] OCC_ZERO  = 3'd0;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Code rule check: complementary end bits, and c1/c2 never both set.
  function automatic logic code_valid(input logic [3:0] c);
    return (c[3] == ~c[0]) && !(c[1] && c[2]);
  endfunction

  // Packs the recovered fields as {sym2, pair_eq, pair_val, err}.
  function automatic logic [3:0] decode_entry(input logic [3:0] c, input logic err);
    logic pair_eq;
    pair_eq = ~c[1];
    return {c[0], pair_eq, pair_eq & (c[2] ^ c[0]), err};
  endfunction

  // Pointer increment with explicit wrap at FIFO_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : (p + PTR_W'(1));
  endfunction

  logic [3:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_next_s, rd_ptr_next_s;
  logic [OCC_W-1:0] occ_r, occ_next_s;
  logic [3:0]       head_r, head_next_s;
  logic [3:0]       entry_s;
  logic             out_valid_r;

  state_t           state_r, state_next_s;
  logic             in_ready_r, in_ready_next_s;
  logic [CNT_W-1:0] err_cnt_r, err_cnt_next_s;
  logic             err_sticky_r, err_sticky_next_s;

  logic             word_valid_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;

  // Decode the incoming word and derive the handshake events.
  always_comb begin
    word_valid_s = code_valid(in_code);
    accept_s     = in_valid & in_ready_r;
    pop_s        = out_valid_r & out_ready;
`ifdef B1R2_DEC_DROP_INVALID_EN
    entry_s      = decode_entry(in_code, 1'b0);
    push_s       = accept_s & word_valid_s;
`else
    entry_s      = decode_entry(in_code, ~word_valid_s);
    push_s       = accept_s;
`endif
  end

  // Next pointers, occupancy and head-of-FIFO contents.
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    occ_next_s    = occ_r;
    head_next_s   = head_r;

    if (push_s) begin
      wr_ptr_next_s = ptr_inc(wr_ptr_r);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_next_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_r + OCC_ONE;
      2'b01:   occ_next_s = occ_r - OCC_ONE;
      default: occ_next_s = occ_r;
    endcase

    // A push that leaves exactly one entry means the pushed word is the new
    // head (either the FIFO was empty, or its only entry is popped now), so
    // it bypasses the storage array. Otherwise the head is already stored.
    if (push_s && (occ_next_s == OCC_ONE)) begin
      head_next_s = entry_s;
    end else if (occ_next_s != OCC_ZERO) begin
      head_next_s = mem_r[rd_ptr_next_s];
    end else begin
      head_next_s = head_r;
    end
  end

  // Error statistics; a clear on the same edge as an invalid word wins.
  always_comb begin
    err_cnt_next_s    = err_cnt_r;
    err_sticky_next_s = err_sticky_r;
    if (clr_err) begin
      err_cnt_next_s    = CNT_ZERO;
      err_sticky_next_s = 1'b0;
    end else if (accept_s && !word_valid_s) begin
      err_sticky_next_s = 1'b1;
      if (err_cnt_r != CNT_MAX) begin
        err_cnt_next_s = err_cnt_r + CNT_ONE;
      end else begin
        err_cnt_next_s = err_cnt_r;
      end
    end else begin
      err_cnt_next_s    = err_cnt_r;
      err_sticky_next_s = err_sticky_r;
    end
  end

  // Run/flush decision and the registered ready for the next cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (err_cnt_next_s == CNT_MAX) begin
          state_next_s = ST_FLUSH;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // No words are accepted in FLUSH, so err_cnt can only have left
        // saturation through a clr_err seen earlier in this FLUSH episode.
        if ((occ_r == OCC_ZERO) && (clr_err || (err_cnt_r != CNT_MAX))) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_FLUSH;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
    in_ready_next_s = (state_next_s == ST_RUN) && (occ_next_s != DEPTH_OCC);
  end

  // FIFO storage, pointers, occupancy and the registered head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 4'b0000;
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      occ_r       <= OCC_ZERO;
      head_r      <= 4'b0000;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= entry_s;
      end
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      occ_r       <= occ_next_s;
      head_r      <= head_next_s;
      out_valid_r <= (occ_next_s != OCC_ZERO);
    end
  end

  // Control FSM with its registered ready output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= in_ready_next_s;
    end
  end

  // Saturating invalid-word counter and sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r    <= CNT_ZERO;
      err_sticky_r <= 1'b0;
    end else begin
      err_cnt_r    <= err_cnt_next_s;
      err_sticky_r <= err_sticky_next_s;
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_sym2     = head_r[3];
  assign out_pair_eq  = head_r[2];
  assign out_pair_val = head_r[1];
  assign out_err      = head_r[0];
  assign err_cnt      = err_cnt_r;
  assign err_sticky   = err_sticky_r;

endmodule

// File: doc/b1r2_code_decoder.md
Name: b1r2_code_decoder

Overview:
- Receive side of the 3-to-4 b1_r2 code: accepts 4-bit code words (c[0]..c[3]) over a valid/ready stream.
- Checks each word against the code rules and recovers the original symbol fields.
- Buffers results in a 2-entry output FIFO and keeps saturating error statistics.
- Sits between the code-word channel and the consumer of decoded 3-bit symbols.

Parameters:
- CNT_W, 8, width of the saturating invalid-word counter
- FIFO_DEPTH, 2, output buffer entries; legal values 2 or 4 only

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  code word present
- in_ready  out  1  decoder can accept a word this cycle
- in_code  in  4  code word; bit0=c0, bit1=c1, bit2=c2, bit3=c3
- out_valid  out  1  decoded entry available
- out_ready  in  1  consumer accepts the entry
- out_sym2  out  1  recovered symbol bit 2 (= c0)
- out_pair_eq  out  1  symbol bits 0 and 1 were equal (= ~c1)
- out_pair_val  out  1  value of bits 0/1 when out_pair_eq=1 (= c2 ^ c0); 0 when out_pair_eq=0
- out_err  out  1  word violated the code rules
- err_cnt  out  CNT_W  count of invalid words accepted, saturating
- err_sticky  out  1  set on first invalid word; cleared only by reset or clr_err
- clr_err  in  1  synchronous clear of err_cnt and err_sticky

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty, out_valid=0, out_* data=0, err_cnt=0, err_sticky=0. in_ready goes high on the first clock edge after reset release.
- Accept rule: a transfer happens on an edge where in_valid & in_ready.
  - in_ready = FIFO not full.
  - in_ready must not depend combinationally on out_ready.
- Validity: a word is valid iff c3 == ~c0 AND NOT (c1 & c2). Both terms must hold.
- Decode is combinational on in_code. The entry is written into the FIFO on the accept edge.
- Latency: out_valid rises one cycle after acceptance when the FIFO was empty.
- Output rules:
  - out_* data come from the FIFO head register.
  - Data must stay stable while out_valid=1 and out_ready=0.
  - Ordering is strictly preserved.
- Simultaneous push and pop when full: no push (in_ready=0), pop proceeds.
- Simultaneous push and pop when partially full: both take effect; occupancy unchanged.
- Pointers: wrap modulo FIFO_DEPTH; full/empty are tracked with an explicit occupancy counter.
- err_cnt: increments by 1 on each accepted invalid word and saturates at 2^CNT_W-1.
- clr_err same cycle as an accepted invalid word: clear wins. err_cnt becomes 0, err_sticky becomes 0, and the word is still forwarded with out_err=1.
- FSM, 2 states:
  - RUN: normal operation.
  - FLUSH: entered when err_cnt reaches saturation. in_ready=0 while the FIFO drains. Returns to RUN on clr_err once the FIFO is empty.
  - clr_err while the FIFO is non-empty in FLUSH: clears err_cnt and err_sticky, but the state stays FLUSH until the FIFO is empty. On the first cycle with the FIFO empty, the FSM returns to RUN without another clr_err.
- Reset mid-transfer: all buffered entries are discarded immediately.

Optional Feature:
- Macro: B1R2_DEC_DROP_INVALID_EN.
- Defined:
  - Invalid words are accepted (in_ready unaffected) and counted, but never written to the FIFO.
  - out_err is tied to 0.
- Undefined: invalid words are forwarded with out_err=1 (default).

Test Plan:
- Reset release, then in_code=4'b1001 (c0=1,c3=1) → invalid. out_valid one cycle later, out_err=1, err_cnt=1, err_sticky=1.
- in_code=4'b1000 (c3=1, c2=0, c1=0, c0=0) → out_sym2=0, out_pair_eq=1, out_pair_val=0, out_err=0.
- Stream 4'b0101, 4'b0011, 4'b0001 with out_ready=0 → in_ready falls after 2 accepts. Third word is held upstream. After out_ready=1, outputs come in order:
  - (1,1,0) — 4'b0101: c0=1, c1=0, c2=1; pair_val = c2^c0 = 0.
  - (1,0,0) — 4'b0011: c1=1, c2=0; pair_eq=0.
  - (1,1,1) — 4'b0001: c0=1, c1=0, c2=0; pair_val = 0^1 = 1.
- Saturation, CNT_W=2: send 3 invalid words → err_cnt=3, FSM in FLUSH, in_ready=0 until FIFO empty and clr_err pulsed. Then err_cnt=0 and in_ready=1.
- clr_err asserted on the same edge as an accepted invalid word → err_cnt=0, err_sticky=0, entry still carries out_err=1.
- Assert rst_n=0 with 2 entries buffered → out_valid drops to 0 asynchronously. After release, no stale entries appear.
- With B1R2_DEC_DROP_INVALID_EN defined: send 4'b0110, 4'b1000.
  - 4'b0110 is invalid (c1&c2): counted, not forwarded.
  - Only one output entry appears: (0,1,0), out_err=0. err_cnt=1.
